conv_kernel_sequencer: RTL and testbench
========================================

// Module: conv_kernel_sequencer
// PURPOSE
//  Parametrised kernel/mode controller for the 3x3 (generalisable KxK) convolution datapath.
//  Debounces the mode button and holds a table of NUM_KERNELS coefficient sets with per-mode biases.
//  Swaps the active set only at a frame boundary, after the engine has drained.
//  Shifts, clamps and packs the engine's three-channel result to RGB565.
// PARAMETERS
//  NUM_KERNELS      4      selectable kernel sets; index wraps at NUM_KERNELS-1 -> 0
//  KW               3      kernel width; TAPS = KW*KW
//  COEF_W           6      signed coefficient width
//  BIAS_W           10     signed scale_bias width
//  ACC_W            16     signed per-channel result width from engine
//  DEBOUNCE_CYCLES  50000  stable-level cycles required to accept a press or release
//  MAX_INFLIGHT     8      max pixels accepted but not yet returned by engine
// PORTS
//  clk            in   1               system clock
//  reset_n        in   1               async active-low reset
//  btn_n          in   1               raw mode button, active-low, asynchronous
//  in_valid       in   1               pixel window available from line buffer
//  in_sof         in   1               qualifies in_valid: first window of a frame
//  out_ready      in   1               downstream can absorb results
//  in_ready       out  1               window accepted this cycle (in_valid && in_ready)
//  kernel         out  TAPS*COEF_W     active coefficients, tap 0 in LSBs, signed
//  scale_bias_g   out  BIAS_W          active green bias
//  scale_bias_rb  out  BIAS_W          active red/blue bias
//  conv_valid     in   1               engine result valid
//  conv_result    in   3*ACC_W         {R,G,B} signed channel sums
//  pixel_valid    out  1               out_pixel valid
//  out_pixel      out  16              RGB565
//  active_sel     out  $clog2(NUM_KERNELS)  kernel index in use
//  pending_sel    out  $clog2(NUM_KERNELS)  kernel index requested by button
// BEHAVIOUR
//  Reset (async, all regs):
//   - active_sel = pending_sel = 0; kernel = identity; biases = 0.
//   - pixel_valid = 0; out_pixel = 0; in_ready = 0; inflight = 0; FSM = RUN.
//  Button path:
//   - 2-FF synchroniser, then a counter that must see DEBOUNCE_CYCLES consecutive equal levels.
//   - Accepted press (stable 0) increments pending_sel once, mod NUM_KERNELS.
//   - Re-arms only after an accepted release (stable 1).
//   - Glitches shorter than DEBOUNCE_CYCLES are ignored.
//  Inflight counter:
//   - +1 on accept, -1 on conv_valid; both in the same cycle -> unchanged.
//   - Never exceeds MAX_INFLIGHT and never underflows (conv_valid at 0 is ignored and flagged by an SVA).
//  FSM:
//   - RUN: in_ready = out_ready && inflight<MAX_INFLIGHT && !(in_valid && in_sof && pending_sel!=active_sel).
//     That last term is combinational from in_valid/in_sof.
//     When the blocking term is true, go to DRAIN; the SOF window is held, not accepted.
//   - DRAIN: in_ready = 0; wait until inflight == 0, then go to LOAD.
//   - LOAD: one cycle. active_sel <= pending_sel; kernel and biases <= table[pending_sel]; go to RUN.
//     The held SOF window is accepted in RUN on the next cycle with the new coefficients.
//  Coefficient stability:
//   - kernel and biases change only in LOAD, so a frame never mixes kernels.
//   - Button presses during DRAIN/LOAD update pending_sel only; they apply at the next SOF.
//  Output stage (1-cycle latency):
//   - pixel_valid(t+1) = conv_valid(t).
//   - Each channel is arithmetically shifted right by table SHIFT[active_sel].
//   - Clamp: G to [0,63]; R,B to [0,31]. Negative -> 0; overflow -> max.
//   - Pack as {R[4:0],G[5:0],B[4:0]}.
//   - out_pixel holds its value when pixel_valid = 0.
//  Reset mid-frame:
//   - All state clears immediately; inflight results still arriving afterwards are dropped.
//   - The engine must be reset with the same reset_n.
// STRUCTURE
//  Package conv_kernel_pkg holds:
//   - kernel_set_t (coef array, bias_g, bias_rb, shift) and KERNEL_TABLE, with:
//     0 identity {0,0,0,0,1,0,0,0,0}, bias 0/0
//     1 sharpen {0,-1,0,-1,5,-1,0,-1,0}, bias 384/256
//     2 emboss {-2,-1,0,-1,1,1,0,1,2}, bias 384/256
//     3 h-edge {-1,-1,-1,0,0,0,1,1,1}, bias 0/0
//     All shifts 0.
//   - The FSM state enum.
//  Sub-module button_debouncer (synchroniser + counter; outputs a 1-cycle press pulse).
// TESTING
//  1 Reset, then SOF window with in_valid=1, out_ready=1
//    -> in_ready=1; kernel=identity; scale_bias_g = scale_bias_rb = 0.
//  2 btn_n low for 10 cycles (DEBOUNCE_CYCLES=16)
//    -> pending_sel stays 0.
//    Low for 20 cycles -> pending_sel=1 exactly once.
//    Then held low for 1000 cycles -> no further increment.
//  3 pending_sel=1, 3 pixels in flight, SOF arrives
//    -> in_ready=0 until the 3rd conv_valid, then one LOAD cycle;
//    -> kernel=sharpen, scale_bias_g=384, scale_bias_rb=256; SOF accepted the next cycle.
//  4 conv_result R=-5, G=70, B=17 (shift 0)
//    -> one cycle later pixel_valid=1, out_pixel={5'd0,6'd63,5'd17}=16'h07F1.
//  5 out_ready=0, or inflight=MAX_INFLIGHT with no conv_valid
//    -> in_ready=0.
//    Simultaneous accept and conv_valid at inflight=MAX_INFLIGHT-1 -> count unchanged.
//  6 Four accepted presses -> pending_sel wraps 3->0.
//    reset_n pulsed low mid-DRAIN -> state RUN, active_sel=0, pixel_valid=0 asynchronously.

Source files
------------

// File: rtl/conv_kernel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_kernel_pkg
// Description : Shared types and constants for the convolution kernel
//               sequencer. Holds the kernel coefficient table, per-set biases
//               and output shifts, plus the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_kernel_pkg;

    localparam int PKG_NUM_KERNELS = 4;
    localparam int PKG_TAPS        = 9;
    localparam int PKG_COEF_W      = 8;

    // coef is declared ascending so that, in a concatenation,
    // the leftmost element lands in tap 0.
    typedef struct packed {
        logic [0:PKG_TAPS-1][PKG_COEF_W-1:0] coef;
        logic signed [15:0]                  bias_g;
        logic signed [15:0]                  bias_rb;
        logic [3:0]                          shift;
    } kernel_set_t;

    localparam kernel_set_t KERNEL_TABLE [PKG_NUM_KERNELS] = '{
        // 0: identity
        '{ {8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0},
           16'sd0, 16'sd0, 4'd0 },
        // 1: sharpen
        '{ {8'sd0, -8'sd1, 8'sd0, -8'sd1, 8'sd5, -8'sd1, 8'sd0, -8'sd1, 8'sd0},
           16'sd384, 16'sd256, 4'd0 },
        // 2: emboss
        '{ {-8'sd2, -8'sd1, 8'sd0, -8'sd1, 8'sd1, 8'sd1, 8'sd0, 8'sd1, 8'sd2},
           16'sd384, 16'sd256, 4'd0 },
        // 3: horizontal edge
        '{ {-8'sd1, -8'sd1, -8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd1, 8'sd1},
           16'sd0, 16'sd0, 4'd0 }
    };

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Two-flop synchroniser followed by a stability counter for an
//               active-low push button. Emits a one-cycle press pulse when a
//               stable low level is accepted; re-arms only after a stable
//               high level has been accepted.
// Ports       : clk, reset_n   - clock, async active-low reset
//               btn_n_i        - raw asynchronous button (active-low)
//               press_o        - one-cycle pulse per accepted press
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_at_limit;

    assign w_at_limit = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    // cnt_q counts consecutive samples that differ from the accepted level;
    // any sample agreeing with the accepted level restarts the count, so
    // short glitches never reach the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (w_at_limit) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
                press_q  <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/conv_kernel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_kernel_sequencer
// Description : Kernel/mode controller for the KxK convolution datapath.
//               Button selects a pending kernel set; the active set is only
//               swapped at a frame start after the engine has drained.
//               Engine results are shifted, clamped and packed to RGB565.
// Ports       : clk, reset_n            - clock, async active-low reset
//               btn_n                   - raw mode button (active-low)
//               in_valid/in_sof/in_ready- window handshake from line buffer
//               out_ready               - downstream back-pressure
//               kernel, scale_bias_*    - active coefficient set to engine
//               conv_valid/conv_result  - engine result {R,G,B}
//               pixel_valid/out_pixel   - RGB565 output
//               active_sel/pending_sel  - kernel index in use / requested
// Revision    : 1.0 - initial release
// ============================================================================
module conv_kernel_sequencer
    import conv_kernel_pkg::*;
#(
    parameter int NUM_KERNELS     = 4,
    parameter int KW              = 3,
    parameter int COEF_W          = 6,
    parameter int BIAS_W          = 10,
    parameter int ACC_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MAX_INFLIGHT    = 8,
    localparam int TAPS  = KW * KW,
    localparam int SEL_W = $clog2(NUM_KERNELS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   btn_n,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic                   out_ready,
    output logic                   in_ready,
    output logic [TAPS*COEF_W-1:0] kernel,
    output logic [BIAS_W-1:0]      scale_bias_g,
    output logic [BIAS_W-1:0]      scale_bias_rb,
    input  logic                   conv_valid,
    input  logic [3*ACC_W-1:0]     conv_result,
    output logic                   pixel_valid,
    output logic [15:0]            out_pixel,
    output logic [SEL_W-1:0]       active_sel,
    output logic [SEL_W-1:0]       pending_sel
);

    localparam int IF_W = $clog2(MAX_INFLIGHT + 1);

    // Table entries beyond the stored sets (or taps beyond 3x3) read as zero.
    function automatic logic [TAPS*COEF_W-1:0] pack_kernel(input int idx);
        logic [TAPS*COEF_W-1:0] k_bits;
        logic signed [31:0]     c;
        k_bits = '0;
        for (int t = 0; t < TAPS && t < PKG_TAPS; t++) begin
            c = 32'(signed'(KERNEL_TABLE[idx].coef[t]));
            k_bits[t*COEF_W +: COEF_W] = c[COEF_W-1:0];
        end
        return k_bits;
    endfunction

    function automatic logic [BIAS_W-1:0] trim_bias(input logic signed [15:0] b);
        logic signed [31:0] w;
        w = 32'(b);
        return w[BIAS_W-1:0];
    endfunction

    function automatic logic [4:0] clamp5(input logic signed [ACC_W-1:0] v);
        if (v < 0)  return 5'd0;
        if (v > 31) return 5'd31;
        return 5'(v);
    endfunction

    function automatic logic [5:0] clamp6(input logic signed [ACC_W-1:0] v);
        if (v < 0)  return 6'd0;
        if (v > 63) return 6'd63;
        return 6'(v);
    endfunction

    localparam logic [TAPS*COEF_W-1:0] IDENTITY_KERNEL = pack_kernel(0);

    seq_state_t             state_q;
    logic [SEL_W-1:0]       active_sel_q;
    logic [SEL_W-1:0]       pending_sel_q;
    logic [SEL_W-1:0]       pending_sel_d;
    logic [TAPS*COEF_W-1:0] kernel_q;
    logic [BIAS_W-1:0]      bias_g_q;
    logic [BIAS_W-1:0]      bias_rb_q;
    logic [3:0]             shift_q;
    logic [IF_W-1:0]        inflight_q;
    logic [IF_W-1:0]        inflight_d;
    logic                   pixel_valid_q;
    logic [15:0]            out_pixel_q;

    logic                   w_press;
    logic                   w_swap_req;
    logic                   w_accept;
    logic                   w_retire;
    int                     w_load_idx;
    logic signed [ACC_W-1:0] w_r;
    logic signed [ACC_W-1:0] w_g;
    logic signed [ACC_W-1:0] w_b;
    logic [15:0]            w_pixel;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_n_i(btn_n),
        .press_o(w_press)
    );

    // A frame start that would need a different kernel is held off
    // combinationally so it is never accepted with stale coefficients.
    assign w_swap_req = in_valid && in_sof && (pending_sel_q != active_sel_q);
    assign in_ready   = reset_n && (state_q == ST_RUN) && out_ready
                        && (inflight_q < IF_W'(MAX_INFLIGHT)) && !w_swap_req;
    assign w_accept   = in_valid && in_ready;
    assign w_retire   = conv_valid && (inflight_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        if (w_accept && !w_retire) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!w_accept && w_retire) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_comb begin
        pending_sel_d = pending_sel_q;
        if (w_press) begin
            pending_sel_d = (pending_sel_q == SEL_W'(NUM_KERNELS - 1)) ? '0
                                                                        : pending_sel_q + 1'b1;
        end
    end

    assign w_load_idx = (int'(pending_sel_q) < PKG_NUM_KERNELS) ? int'(pending_sel_q) : 0;

    // Sequencer: swaps coefficients only in LOAD, after the engine is empty.
    // DRAIN looks at the next-state count so LOAD follows the last retire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            active_sel_q <= '0;
            kernel_q     <= IDENTITY_KERNEL;
            bias_g_q     <= '0;
            bias_rb_q    <= '0;
            shift_q      <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (w_swap_req) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (inflight_d == '0) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    state_q      <= ST_RUN;
                    active_sel_q <= pending_sel_q;
                    kernel_q     <= pack_kernel(w_load_idx);
                    bias_g_q     <= trim_bias(KERNEL_TABLE[w_load_idx].bias_g);
                    bias_rb_q    <= trim_bias(KERNEL_TABLE[w_load_idx].bias_rb);
                    shift_q      <= KERNEL_TABLE[w_load_idx].shift;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign w_r     = signed'(conv_result[3*ACC_W-1 -: ACC_W]) >>> shift_q;
    assign w_g     = signed'(conv_result[2*ACC_W-1 -: ACC_W]) >>> shift_q;
    assign w_b     = signed'(conv_result[ACC_W-1 -: ACC_W]) >>> shift_q;
    assign w_pixel = {clamp5(w_r), clamp6(w_g), clamp5(w_b)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q    <= '0;
            pending_sel_q <= '0;
            pixel_valid_q <= 1'b0;
            out_pixel_q   <= '0;
        end else begin
            inflight_q    <= inflight_d;
            pending_sel_q <= pending_sel_d;
            pixel_valid_q <= conv_valid;
            if (conv_valid) out_pixel_q <= w_pixel;
        end
    end

    // A result with nothing in flight means the engine and this block
    // disagree about outstanding work.
    a_no_retire_when_empty: assert property (
        @(posedge clk) disable iff (!reset_n) conv_valid |-> (inflight_q != '0)
    );

    assign kernel        = kernel_q;
    assign scale_bias_g  = bias_g_q;
    assign scale_bias_rb = bias_rb_q;
    assign pixel_valid   = pixel_valid_q;
    assign out_pixel     = out_pixel_q;
    assign active_sel    = active_sel_q;
    assign pending_sel   = pending_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_kernel_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_conv_kernel_sequencer
// Description : Self-checking bench for conv_kernel_sequencer with a
//               behavioural model (kernel table, pending/active selection,
//               in-flight count, RGB565 clamping) and randomised traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_kernel_sequencer;

    localparam int DEB  = 16;
    localparam int MAXF = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        btn_n;
    logic        in_valid;
    logic        in_sof;
    logic        out_ready;
    logic        in_ready;
    logic [53:0] kernel;
    logic [9:0]  scale_bias_g;
    logic [9:0]  scale_bias_rb;
    logic        conv_valid;
    logic [47:0] conv_result;
    logic        pixel_valid;
    logic [15:0] out_pixel;
    logic [1:0]  active_sel;
    logic [1:0]  pending_sel;

    always #5 clk = ~clk;

    conv_kernel_sequencer #(
        .NUM_KERNELS    (4),
        .KW             (3),
        .COEF_W         (6),
        .BIAS_W         (10),
        .ACC_W          (16),
        .DEBOUNCE_CYCLES(DEB),
        .MAX_INFLIGHT   (MAXF)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_n        (btn_n),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .out_ready    (out_ready),
        .in_ready     (in_ready),
        .kernel       (kernel),
        .scale_bias_g (scale_bias_g),
        .scale_bias_rb(scale_bias_rb),
        .conv_valid   (conv_valid),
        .conv_result  (conv_result),
        .pixel_valid  (pixel_valid),
        .out_pixel    (out_pixel),
        .active_sel   (active_sel),
        .pending_sel  (pending_sel)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int coefs   [4][9] = '{'{0, 0, 0, 0, 1, 0, 0, 0, 0},
                           '{0, -1, 0, -1, 5, -1, 0, -1, 0},
                           '{-2, -1, 0, -1, 1, 1, 0, 1, 2},
                           '{-1, -1, -1, 0, 0, 0, 1, 1, 1}};
    int bias_g  [4]    = '{0, 384, 384, 0};
    int bias_rb [4]    = '{0, 256, 256, 0};
    int shifts  [4]    = '{0, 0, 0, 0};

    int          m_inflight;
    int          m_pending;
    int          m_active;
    bit          m_blocked;
    logic [15:0] m_pix;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [53:0] exp_kernel(input int s);
        logic [53:0] k;
        logic [5:0]  c6;
        k = '0;
        for (int t = 0; t < 9; t++) begin
            c6 = 6'(coefs[s][t]);
            k[t*6 +: 6] = c6;
        end
        return k;
    endfunction

    function automatic logic [15:0] model_pixel(input logic [47:0] res, input int sh);
        int r, g, b;
        r = int'($signed(res[47:32])) >>> sh;
        g = int'($signed(res[31:16])) >>> sh;
        b = int'($signed(res[15:0]))  >>> sh;
        r = (r < 0) ? 0 : (r > 31) ? 31 : r;
        g = (g < 0) ? 0 : (g > 63) ? 63 : g;
        b = (b < 0) ? 0 : (b > 31) ? 31 : b;
        return 16'(r * 2048 + g * 32 + b);
    endfunction

    function automatic logic [15:0] rand_chan();
        int v;
        case ($urandom_range(0, 2))
            0:       v = int'($urandom_range(0, 70));
            1:       v = -int'($urandom_range(1, 1000));
            default: v = int'($urandom_range(0, 65535)) - 32768;
        endcase
        return 16'(v);
    endfunction

    function automatic logic [47:0] rand_res();
        return {rand_chan(), rand_chan(), rand_chan()};
    endfunction

    // One clock of stimulus: checks in_ready before the edge and the
    // output pixel after it, advancing the model in between.
    task automatic cycle(input bit iv, input bit sof, input bit ordy,
                         input bit cv, input logic [47:0] res);
        bit exp_rdy;
        bit acc;
        in_valid    = iv;
        in_sof      = sof;
        out_ready   = ordy;
        conv_valid  = cv;
        conv_result = res;
        #1;
        exp_rdy = !m_blocked && ordy && (m_inflight < MAXF)
                  && !(iv && sof && (m_pending != m_active));
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc = iv && exp_rdy;
        if (cv) m_pix = model_pixel(res, shifts[m_active]);
        @(posedge clk);
        #2;
        m_inflight = m_inflight + int'(acc) - int'(cv && (m_inflight > 0));
        check("pixel_valid", 64'(pixel_valid), 64'(cv));
        check("out_pixel", 64'(out_pixel), 64'(m_pix));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic press();
        btn_n = 1'b0;
        repeat (DEB + 6) idle();
        btn_n = 1'b1;
        repeat (DEB + 6) idle();
        m_pending = (m_pending + 1) % 4;
        check("pending_after_press", 64'(pending_sel), 64'(m_pending));
    endtask

    task automatic model_reset();
        m_inflight = 0;
        m_pending  = 0;
        m_active   = 0;
        m_blocked  = 1'b0;
        m_pix      = '0;
    endtask

    initial begin
        model_reset();
        reset_n     = 1'b0;
        btn_n       = 1'b1;
        in_valid    = 1'b1;
        in_sof      = 1'b1;
        out_ready   = 1'b1;
        conv_valid  = 1'b0;
        conv_result = '0;
        repeat (3) @(posedge clk);
        #2;
        // Reset state
        check("rst_in_ready",    64'(in_ready),      64'(0));
        check("rst_pixel_valid", 64'(pixel_valid),   64'(0));
        check("rst_out_pixel",   64'(out_pixel),     64'(0));
        check("rst_active_sel",  64'(active_sel),    64'(0));
        check("rst_pending_sel", 64'(pending_sel),   64'(0));
        check("rst_kernel",      64'(kernel),        64'(exp_kernel(0)));
        check("rst_bias_g",      64'(scale_bias_g),  64'(0));
        check("rst_bias_rb",     64'(scale_bias_rb), 64'(0));
        reset_n = 1'b1;

        // First SOF accepted with identity coefficients, then the clamp case
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check("t1_kernel", 64'(kernel), 64'(exp_kernel(0)));
        cycle(1'b0, 1'b0, 1'b1, 1'b1, {16'hFFFB, 16'd70, 16'd17});
        check("t4_pixel_const", 64'(out_pixel), 64'h07F1);

        // Button: short glitch ignored, long press counts once
        btn_n = 1'b0;
        repeat (10) idle();
        btn_n = 1'b1;
        repeat (30) idle();
        check("glitch_pending", 64'(pending_sel), 64'(0));
        btn_n = 1'b0;
        repeat (20) idle();
        m_pending = 1;
        check("press_pending", 64'(pending_sel), 64'(1));
        repeat (1000) idle();
        check("held_pending", 64'(pending_sel), 64'(1));
        btn_n = 1'b1;
        repeat (30) idle();
        check("release_pending", 64'(pending_sel), 64'(1));

        // Kernel swap at frame start after three pixels drain
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        m_blocked = 1'b1;
        repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b1, rand_res());
        check("drain_kernel_old", 64'(kernel), 64'(exp_kernel(0)));
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        m_blocked = 1'b0;
        m_active  = m_pending;
        check("load_active_sel", 64'(active_sel),    64'(1));
        check("load_kernel",     64'(kernel),        64'(exp_kernel(1)));
        check("load_bias_g",     64'(scale_bias_g),  64'(bias_g[1]));
        check("load_bias_rb",    64'(scale_bias_rb), 64'(bias_rb[1]));
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, rand_res());

        // Back-pressure and in-flight limit
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (MAXF) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, rand_res());
        cycle(1'b1, 1'b0, 1'b1, 1'b1, rand_res());
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        while (m_inflight > 0) cycle(1'b0, 1'b0, 1'b1, 1'b1, rand_res());

        // Randomised traffic with the pending set already active
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) != 0),
                  (m_inflight > 0) && 1'($urandom_range(0, 1)), rand_res());
        end
        while (m_inflight > 0) cycle(1'b0, 1'b0, 1'b1, 1'b1, rand_res());

        // Selection wraps 3 -> 0 after four presses
        repeat (4) press();
        press();

        // Reset pulsed asynchronously while draining
        repeat (2) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        m_blocked = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 1'b1, rand_res());
        reset_n = 1'b0;
        #1;
        check("arst_pixel_valid", 64'(pixel_valid), 64'(0));
        check("arst_out_pixel",   64'(out_pixel),   64'(0));
        check("arst_active_sel",  64'(active_sel),  64'(0));
        check("arst_pending_sel", 64'(pending_sel), 64'(0));
        check("arst_in_ready",    64'(in_ready),    64'(0));
        check("arst_kernel",      64'(kernel),      64'(exp_kernel(0)));
        #2;
        reset_n = 1'b1;
        model_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, rand_res());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
